// File: rtl/pong_pkg.sv
// Shared Speed Pong definitions: direction codes, ball FSM states and the
// playfield geometry used by the ball, collision and rendering stages.
package pong_pkg;

    typedef enum logic [2:0] {
        LU = 3'd0,
        LM = 3'd1,
        LD = 3'd2,
        RU = 3'd3,
        RM = 3'd4,
        RD = 3'd5
    } dir_t;

    typedef enum logic [1:0] {
        SERVE,
        MOVE,
        GOAL_L,
        GOAL_R
    } ball_state_t;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int BALL_SIZE = 30;
    localparam int X_MIN     = 10;
    localparam int X_MAX     = 630;
    localparam int Y_MIN     = 10;
    localparam int Y_MAX     = 470;

    localparam int CENTER_X1 = (SCREEN_W - BALL_SIZE) / 2;
    localparam int CENTER_Y1 = (SCREEN_H - BALL_SIZE) / 2;

    localparam int POS_W = 10;

endpackage

// File: rtl/ball_motion_if.sv
// Bundle between the collision FSM (master) and the ball motion stage (slave):
// step/direction/hit requests in, bounding box and game events out.
interface ball_motion_if;
    import pong_pkg::*;

    logic             step_en;
    logic [2:0]       dir;
    logic             paddle_hit;
    logic [POS_W-1:0] ball_x1;
    logic [POS_W-1:0] ball_x2;
    logic [POS_W-1:0] ball_y1;
    logic [POS_W-1:0] ball_y2;
    logic             goal_p1;
    logic             goal_p2;
    logic             serving;
    logic [2:0]       speed;

    modport master (
        output step_en, dir, paddle_hit,
        input  ball_x1, ball_x2, ball_y1, ball_y2,
        input  goal_p1, goal_p2, serving, speed
    );

    modport slave (
        input  step_en, dir, paddle_hit,
        output ball_x1, ball_x2, ball_y1, ball_y2,
        output goal_p1, goal_p2, serving, speed
    );
endinterface

// File: rtl/ball_motion_serve_timer.sv
// Counts step pulses while the ball waits at centre; flags the pulse that
// completes the serve delay so the ball FSM can launch on the following clock.
module serve_timer #(
    parameter int SERVE_TICKS = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_step_en,
    output logic o_done
);
    localparam int CW = $clog2(SERVE_TICKS + 1);
    localparam logic [CW-1:0] C_LAST = CW'(SERVE_TICKS - 1);
    localparam logic [CW-1:0] C_TERM = CW'(SERVE_TICKS);

    logic [CW-1:0] r_count;

    // Count step pulses up to the serve length, restarting whenever cleared
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_step_en && (r_count != C_TERM)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_done = i_step_en && !i_clear && (r_count == C_LAST);

endmodule

// File: rtl/ball_motion.sv
// Two-dimensional ball mover for Speed Pong: serve hold at centre, stepwise
// motion with wall clamping, goal detection with recentring, and speed-up
// every few paddle hits.
module ball_motion
    import pong_pkg::*;
#(
    parameter int SERVE_TICKS    = 100,
    parameter int HITS_PER_LEVEL = 4,
    parameter int SPEED_MAX      = 4
) (
    input  logic          clk,
    input  logic          reset,
    ball_motion_if.slave  io_ball
);
    localparam int HW = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

    localparam logic [HW-1:0]    C_HIT_LAST = HW'(HITS_PER_LEVEL - 1);
    localparam logic [2:0]       C_SPD_MAX  = 3'(SPEED_MAX);
    localparam logic [POS_W-1:0] C_CX1      = POS_W'(CENTER_X1);
    localparam logic [POS_W-1:0] C_CY1      = POS_W'(CENTER_Y1);
    localparam logic [POS_W-1:0] C_BALL     = POS_W'(BALL_SIZE);

    localparam logic signed [10:0] S_BALL   = 11'(BALL_SIZE);
    localparam logic signed [10:0] S_XMIN   = 11'(X_MIN);
    localparam logic signed [10:0] S_XMAX   = 11'(X_MAX);
    localparam logic signed [10:0] S_YMIN   = 11'(Y_MIN);
    localparam logic signed [10:0] S_YMAX   = 11'(Y_MAX);
    localparam logic signed [10:0] S_XRIGHT = 11'(X_MAX - BALL_SIZE);
    localparam logic signed [10:0] S_YLOW   = 11'(Y_MAX - BALL_SIZE);

    ball_state_t      r_state;
    logic [POS_W-1:0] r_x1;
    logic [POS_W-1:0] r_x2;
    logic [POS_W-1:0] r_y1;
    logic [POS_W-1:0] r_y2;
    logic [2:0]       r_speed;
    logic [HW-1:0]    r_hits;
    logic             r_goal_p1;
    logic             r_goal_p2;
    logic             r_serving;

    logic signed [10:0] w_step;
    logic signed [10:0] w_dx;
    logic signed [10:0] w_dy;
    logic signed [10:0] w_candX1;
    logic signed [10:0] w_candY1;
    logic signed [10:0] w_resX1;
    logic signed [10:0] w_resY1;
    logic [POS_W-1:0]   w_nextX1;
    logic [POS_W-1:0]   w_nextY1;
    logic               w_toGoalL;
    logic               w_toGoalR;
    logic               w_serveClear;
    logic               w_serveDone;

    assign w_serveClear = (r_state != SERVE);

    serve_timer #(
        .SERVE_TICKS (SERVE_TICKS)
    ) u_serve_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_serveClear),
        .i_step_en (io_ball.step_en),
        .o_done    (w_serveDone)
    );

    // Candidate next position for one step, with wall clamping and goal-line detection
    always_comb begin
        w_step    = {8'd0, r_speed};
        w_dx      = '0;
        w_dy      = '0;
        case (io_ball.dir)
            LU: begin w_dx = -w_step; w_dy = -w_step; end
            LM: begin w_dx = -w_step; end
            LD: begin w_dx = -w_step; w_dy =  w_step; end
            RU: begin w_dx =  w_step; w_dy = -w_step; end
            RM: begin w_dx =  w_step; end
            RD: begin w_dx =  w_step; w_dy =  w_step; end
            default: ;
        endcase

        w_candX1 = $signed({1'b0, r_x1}) + w_dx;
        w_candY1 = $signed({1'b0, r_y1}) + w_dy;

        w_resY1 = w_candY1;
        if (w_candY1 < S_YMIN) begin
            w_resY1 = S_YMIN;
        end else if ((w_candY1 + S_BALL) > S_YMAX) begin
            w_resY1 = S_YLOW;
        end

        w_resX1   = w_candX1;
        w_toGoalL = 1'b0;
        w_toGoalR = 1'b0;
        if (w_candX1 <= S_XMIN) begin
            w_resX1   = S_XMIN;
            w_toGoalL = 1'b1;
        end else if ((w_candX1 + S_BALL) >= S_XMAX) begin
            w_resX1   = S_XRIGHT;
            w_toGoalR = 1'b1;
        end

        w_nextX1 = w_resX1[POS_W-1:0];
        w_nextY1 = w_resY1[POS_W-1:0];
    end

    // Ball FSM: serve hold, stepwise motion, speed-up on hits, one-clock goal then recentre
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= SERVE;
            r_x1      <= C_CX1;
            r_x2      <= C_CX1 + C_BALL;
            r_y1      <= C_CY1;
            r_y2      <= C_CY1 + C_BALL;
            r_speed   <= 3'd1;
            r_hits    <= '0;
            r_goal_p1 <= 1'b0;
            r_goal_p2 <= 1'b0;
            r_serving <= 1'b1;
        end else begin
            r_goal_p1 <= 1'b0;
            r_goal_p2 <= 1'b0;
            case (r_state)
                SERVE: begin
                    if (w_serveDone) begin
                        r_state   <= MOVE;
                        r_serving <= 1'b0;
                    end
                end
                MOVE: begin
                    if (io_ball.step_en) begin
                        r_x1 <= w_nextX1;
                        r_x2 <= w_nextX1 + C_BALL;
                        r_y1 <= w_nextY1;
                        r_y2 <= w_nextY1 + C_BALL;
                        if (w_toGoalL) begin
                            r_state   <= GOAL_L;
                            r_goal_p2 <= 1'b1;
                        end else if (w_toGoalR) begin
                            r_state   <= GOAL_R;
                            r_goal_p1 <= 1'b1;
                        end
                    end
                    if (io_ball.paddle_hit) begin
                        if (r_hits == C_HIT_LAST) begin
                            r_hits <= '0;
                            if (r_speed != C_SPD_MAX) begin
                                r_speed <= r_speed + 3'd1;
                            end
                        end else begin
                            r_hits <= r_hits + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= SERVE;
                    r_x1      <= C_CX1;
                    r_x2      <= C_CX1 + C_BALL;
                    r_y1      <= C_CY1;
                    r_y2      <= C_CY1 + C_BALL;
                    r_speed   <= 3'd1;
                    r_hits    <= '0;
                    r_serving <= 1'b1;
                end
            endcase
        end
    end

    assign io_ball.ball_x1 = r_x1;
    assign io_ball.ball_x2 = r_x2;
    assign io_ball.ball_y1 = r_y1;
    assign io_ball.ball_y2 = r_y2;
    assign io_ball.goal_p1 = r_goal_p1;
    assign io_ball.goal_p2 = r_goal_p2;
    assign io_ball.serving = r_serving;
    assign io_ball.speed   = r_speed;

endmodule
